// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between two masters
// (m0 = cpu, m1 = loader/debug). The grant is a combinational round-robin
// with optional burst lock limited by a fairness counter. The memory command
// is registered one cycle after the grant, and read data is steered back to
// the issuing master through a two-stage tag pipe that matches the memory's
// one-cycle read latency.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  m0_req_i,
    input  logic                  m0_wr_i,
    input  logic                  m0_lock_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_wdata_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,
    input  logic                  m1_req_i,
    input  logic                  m1_wr_i,
    input  logic                  m1_lock_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_wdata_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,
    output logic                  mem_en_o,
    output logic                  mem_rd_en_o,
    output logic                  mem_wr_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_din_o,
    input  logic [DATA_WIDTH-1:0] mem_dout_i
);

    localparam int               CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    typedef enum logic { M0 = 1'b0, M1 = 1'b1 } master_e;

    // Arbitration state: last granted master and its run of consecutive grants.
    master_e          last_gnt;
    logic [CNT_W-1:0] burst_cnt;

    logic             gnt_valid;
    master_e          gnt_id;
    logic             owner_lock;

    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    // Read tag pipe: stage 1 aligns with the memory command, stage 2 with the data.
    logic    rd_vld_q1, rd_vld_q2;
    master_e rd_id_q1, rd_id_q2;

    logic [DATA_WIDTH-1:0] m0_rdata_q, m1_rdata_q;

    // Grant decision: a lone requester wins; on contention the owner keeps the bus
    // only while it holds lock and is under the burst limit.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and infers a latch.
        gnt_valid  = 1'b0;
        gnt_id     = M0;
        owner_lock = (last_gnt == M1) ? m1_lock_i : m0_lock_i;
        if (!rst_i) begin
            if (m0_req_i && m1_req_i) begin
                gnt_valid = 1'b1;
                if (owner_lock && (burst_cnt < MAX_CNT)) begin
                    gnt_id = last_gnt;
                end else begin
                    gnt_id = (last_gnt == M0) ? M1 : M0;
                end
            end else if (m0_req_i) begin
                gnt_valid = 1'b1;
                gnt_id    = M0;
            end else if (m1_req_i) begin
                gnt_valid = 1'b1;
                gnt_id    = M1;
            end
        end
    end

    // Command mux: forward the granted master's command toward the memory register.
    always_comb begin
        if (gnt_id == M1) begin
            sel_wr    = m1_wr_i;
            sel_addr  = m1_addr_i;
            sel_wdata = m1_wdata_i;
        end else begin
            sel_wr    = m0_wr_i;
            sel_addr  = m0_addr_i;
            sel_wdata = m0_wdata_i;
        end
    end

    // Arbitration state update: burst count restarts on a master change and saturates.
    always_ff @(posedge clk_i) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            last_gnt  <= M1;
            burst_cnt <= '0;
        end else if (gnt_valid) begin
            last_gnt <= gnt_id;
            if (gnt_id != last_gnt) begin
                burst_cnt <= CNT_W'(1);
            end else if (burst_cnt != MAX_CNT) begin
                burst_cnt <= burst_cnt + CNT_W'(1);
            end
        end
    end

    // Registered memory command: strobes follow the grant, address/data hold when idle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_en_o    <= 1'b0;
            mem_rd_en_o <= 1'b0;
            mem_wr_en_o <= 1'b0;
            mem_addr_o  <= '0;
            mem_din_o   <= '0;
        end else begin
            mem_en_o    <= gnt_valid;
            mem_rd_en_o <= gnt_valid && !sel_wr;
            mem_wr_en_o <= gnt_valid && sel_wr;
            if (gnt_valid) begin
                mem_addr_o <= sel_addr;
                mem_din_o  <= sel_wdata;
            end
        end
    end

    // Read return path: tag pipe plus per-master hold of the last returned word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_vld_q1  <= 1'b0;
            rd_vld_q2  <= 1'b0;
            rd_id_q1   <= M0;
            rd_id_q2   <= M0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            rd_vld_q1 <= gnt_valid && !sel_wr;
            rd_id_q1  <= gnt_id;
            rd_vld_q2 <= rd_vld_q1;
            rd_id_q2  <= rd_id_q1;
            if (m0_rvalid_o) begin
                m0_rdata_q <= mem_dout_i;
            end
            if (m1_rvalid_o) begin
                m1_rdata_q <= mem_dout_i;
            end
        end
    end

    assign m0_gnt_o    = gnt_valid && (gnt_id == M0);
    assign m1_gnt_o    = gnt_valid && (gnt_id == M1);
    assign m0_rvalid_o = rd_vld_q2 && (rd_id_q2 == M0);
    assign m1_rvalid_o = rd_vld_q2 && (rd_id_q2 == M1);
    assign m0_rdata_o  = m0_rvalid_o ? mem_dout_i : m0_rdata_q;
    assign m1_rdata_o  = m1_rvalid_o ? mem_dout_i : m1_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a behavioural single-port RAM, a reference
// arbitration model with a read scoreboard checked every falling edge, and
// directed sequences for reset, write-then-read, contention, lock/fairness,
// a full-memory loader image and reset during an outstanding read.
module tb_mem_port_arbiter;

    localparam int AW = 12;
    localparam int DW = 16;
    localparam int MB = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          m0_req_i, m0_wr_i, m0_lock_i;
    logic [AW-1:0] m0_addr_i;
    logic [DW-1:0] m0_wdata_i;
    logic          m0_gnt_o, m0_rvalid_o;
    logic [DW-1:0] m0_rdata_o;
    logic          m1_req_i, m1_wr_i, m1_lock_i;
    logic [AW-1:0] m1_addr_i;
    logic [DW-1:0] m1_wdata_i;
    logic          m1_gnt_o, m1_rvalid_o;
    logic [DW-1:0] m1_rdata_o;
    logic          mem_en_o, mem_rd_en_o, mem_wr_en_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_din_o;
    logic [DW-1:0] mem_dout_i;

    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_wr_i(m0_wr_i), .m0_lock_i(m0_lock_i),
        .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
        .m0_gnt_o(m0_gnt_o), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_wr_i(m1_wr_i), .m1_lock_i(m1_lock_i),
        .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
        .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .mem_en_o(mem_en_o), .mem_rd_en_o(mem_rd_en_o), .mem_wr_en_o(mem_wr_en_o),
        .mem_addr_o(mem_addr_o), .mem_din_o(mem_din_o), .mem_dout_i(mem_dout_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Behavioural single-port RAM with one-cycle read latency.
    logic [DW-1:0] ram [1 << AW];
    always @(posedge clk_i) begin
        if (mem_en_o && mem_wr_en_o) ram[mem_addr_o] <= mem_din_o;
        if (mem_en_o && mem_rd_en_o) mem_dout_i <= ram[mem_addr_o];
    end

    // Reference model and scoreboard state.
    typedef struct {
        logic          id;
        logic [DW-1:0] data;
        int            due;
    } rd_t;

    rd_t           sb[$];
    rd_t           ent;
    logic [DW-1:0] shadow [1 << AW];
    int            cyc = 0;
    logic          m_last = 1'b1;
    int            m_burst = 0;
    logic          m_gv, m_gid, m_lk;
    logic          exp_en = 0, exp_rd = 0, exp_wr = 0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_din = '0;
    logic [DW-1:0] exp_rd0 = '0, exp_rd1 = '0;
    logic          exp_rv0, exp_rv1;
    logic          c_wr;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;

    // Per-cycle check of every DUT output against the model, then model update.
    always @(negedge clk_i) begin
        cyc++;
        check("mem_en", mem_en_o, exp_en);
        check("mem_rd_en", mem_rd_en_o, exp_rd);
        check("mem_wr_en", mem_wr_en_o, exp_wr);
        check("mem_addr", mem_addr_o, exp_addr);
        check("mem_din", mem_din_o, exp_din);

        exp_rv0 = 1'b0;
        exp_rv1 = 1'b0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            if (sb[0].id) exp_rv1 = 1'b1;
            else          exp_rv0 = 1'b1;
        end
        check("rvalid_m0", m0_rvalid_o, exp_rv0);
        check("rvalid_m1", m1_rvalid_o, exp_rv1);
        if (exp_rv0) exp_rd0 = sb[0].data;
        if (exp_rv1) exp_rd1 = sb[0].data;
        check("rdata_m0", m0_rdata_o, exp_rd0);
        check("rdata_m1", m1_rdata_o, exp_rd1);
        if (exp_rv0 || exp_rv1) void'(sb.pop_front());

        m_gv  = 1'b0;
        m_gid = 1'b0;
        if (!rst_i) begin
            if (m0_req_i && m1_req_i) begin
                m_gv  = 1'b1;
                m_lk  = m_last ? m1_lock_i : m0_lock_i;
                m_gid = (m_lk && m_burst < MB) ? m_last : !m_last;
            end else if (m0_req_i) begin
                m_gv = 1'b1;
            end else if (m1_req_i) begin
                m_gv  = 1'b1;
                m_gid = 1'b1;
            end
        end
        check("gnt_m0", m0_gnt_o, m_gv && !m_gid);
        check("gnt_m1", m1_gnt_o, m_gv && m_gid);

        if (rst_i) begin
            m_last  = 1'b1;
            m_burst = 0;
            exp_en  = 1'b0;
            exp_rd  = 1'b0;
            exp_wr  = 1'b0;
            exp_addr = '0;
            exp_din  = '0;
            exp_rd0  = '0;
            exp_rd1  = '0;
            sb.delete();
        end else begin
            c_wr    = m_gid ? m1_wr_i    : m0_wr_i;
            c_addr  = m_gid ? m1_addr_i  : m0_addr_i;
            c_wdata = m_gid ? m1_wdata_i : m0_wdata_i;
            exp_en = m_gv;
            exp_rd = m_gv && !c_wr;
            exp_wr = m_gv && c_wr;
            if (m_gv) begin
                exp_addr = c_addr;
                exp_din  = c_wdata;
                if (c_wr) begin
                    shadow[c_addr] = c_wdata;
                end else begin
                    ent.id   = m_gid;
                    ent.data = shadow[c_addr];
                    ent.due  = cyc + 2;
                    sb.push_back(ent);
                end
                m_burst = (m_gid == m_last) ? ((m_burst < MB) ? m_burst + 1 : MB) : 1;
                m_last  = m_gid;
            end
        end
    end

    logic          g0, g1, exp_id;
    int            gcnt;
    logic          exp4 [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        rst_i = 1'b1;
        m0_req_i = 1'b1; m0_wr_i = 1'b1; m0_lock_i = 1'b0; m0_addr_i = 12'h020; m0_wdata_i = 16'h1111;
        m1_req_i = 1'b1; m1_wr_i = 1'b1; m1_lock_i = 1'b0; m1_addr_i = 12'h021; m1_wdata_i = 16'h2222;

        // Reset held two cycles with both masters requesting.
        tick();
        check("t1_rst_gnt_m0", m0_gnt_o, 1'b0);
        check("t1_rst_gnt_m1", m1_gnt_o, 1'b0);
        check("t1_rst_mem_en", mem_en_o, 1'b0);
        check("t1_rst_rvalid", m0_rvalid_o | m1_rvalid_o, 1'b0);
        tick();
        rst_i = 1'b0;
        #1;
        check("t1_first_gnt_m0", m0_gnt_o, 1'b1);
        check("t1_first_gnt_m1", m1_gnt_o, 1'b0);
        tick();
        tick();
        m0_req_i = 1'b0; m1_req_i = 1'b0;
        tick();

        // Write then read of the same address from m0.
        m0_req_i = 1'b1; m0_wr_i = 1'b1; m0_addr_i = 12'h010; m0_wdata_i = 16'hBEEF;
        #1;
        check("t2_wr_gnt", m0_gnt_o, 1'b1);
        tick();
        m0_wr_i = 1'b0;
        #1;
        check("t2_mem_wr_en", mem_wr_en_o, 1'b1);
        check("t2_rd_gnt", m0_gnt_o, 1'b1);
        tick();
        m0_req_i = 1'b0;
        tick();
        check("t2_rvalid", m0_rvalid_o, 1'b1);
        check("t2_rdata", m0_rdata_o, 16'hBEEF);
        tick();

        // Loader image: m1 writes data = addr over the whole memory, m0 idle.
        gcnt = 0;
        m1_wr_i = 1'b1;
        for (int i = 0; i < (1 << AW); i++) begin
            m1_req_i   = 1'b1;
            m1_addr_i  = AW'(i);
            m1_wdata_i = DW'(i);
            #1;
            if (m1_gnt_o) gcnt++;
            tick();
        end
        m1_req_i = 1'b0;
        check("t5_gnt_count", gcnt, 1 << AW);
        m0_req_i = 1'b1; m0_wr_i = 1'b0; m0_addr_i = 12'hFFF;
        tick();
        m0_req_i = 1'b0;
        tick();
        check("t5_rvalid", m0_rvalid_o, 1'b1);
        check("t5_rdata", m0_rdata_o, 16'h0FFF);
        tick();

        // Contention without lock: grants alternate, starting with m1 since m0 went last.
        m0_req_i = 1'b1; m0_wr_i = 1'b0; m0_addr_i = 12'h040;
        m1_req_i = 1'b1; m1_wr_i = 1'b0; m1_addr_i = 12'h840;
        exp_id = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("t3_alt_m1", m1_gnt_o, exp_id);
            check("t3_alt_m0", m0_gnt_o, !exp_id);
            g0 = m0_gnt_o;
            g1 = m1_gnt_o;
            exp_id = !exp_id;
            tick();
            if (g0) m0_addr_i = m0_addr_i + 12'd1;
            if (g1) m1_addr_i = m1_addr_i + 12'd1;
        end
        m0_req_i = 1'b0; m1_req_i = 1'b0;
        tick();
        tick();
        tick();

        // Lock + fairness: m1 keeps the bus for MAX_BURST grants, m0 gets one, m1 resumes.
        m0_req_i = 1'b1; m0_addr_i = 12'h100;
        m1_req_i = 1'b1; m1_addr_i = 12'h200; m1_lock_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("t4_gnt_m1", m1_gnt_o, exp4[i]);
            check("t4_gnt_m0", m0_gnt_o, !exp4[i]);
            tick();
        end
        m0_req_i = 1'b0; m1_req_i = 1'b0; m1_lock_i = 1'b0;
        tick();
        tick();
        tick();

        // Reset one cycle after an m1 read is granted: the read never returns.
        m1_req_i = 1'b1; m1_wr_i = 1'b0; m1_addr_i = 12'h321;
        #1;
        check("t6_rd_gnt", m1_gnt_o, 1'b1);
        tick();
        m1_req_i = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t6_no_rvalid", m1_rvalid_o, 1'b0);
            tick();
        end
        m0_req_i = 1'b1; m0_addr_i = 12'h005;
        m1_req_i = 1'b1; m1_addr_i = 12'h006;
        #1;
        check("t6_restart_m0", m0_gnt_o, 1'b1);
        tick();
        m0_req_i = 1'b0; m1_req_i = 1'b0;

        repeat (4) tick();
        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
